// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read address/data channel pair between the
// icache and dcache read ports; a single burst is in flight at a time.
module axi_rd_arbiter #(
    parameter logic [3:0] ICACHE_ID = 4'd0,
    parameter logic [3:0] DCACHE_ID = 4'd1,
    parameter bit         FAIR      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_r_req,
    input  logic [31:0] i_r_addr,
    input  logic [2:0]  i_r_size,
    input  logic [7:0]  i_r_length,
    input  logic        i_r_data_ready,
    output logic        i_r_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_r_data,

    input  logic        d_r_req,
    input  logic [31:0] d_r_addr,
    input  logic [2:0]  d_r_size,
    input  logic [7:0]  d_r_length,
    input  logic        d_r_data_ready,
    output logic        d_r_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_r_data,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R
    } state_e;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [3:0]  arid_q, arid_d;

    logic        grant;
    logic        ar_hs;
    logic        in_r;
    logic        own_i;
    logic        own_d;

    // Tie-break: alternate away from the last winner, or favour the dcache.
    always_comb begin
        grant = SEL_I;
        if (i_r_req && d_r_req) begin
            grant = FAIR ? ~last_grant_q : SEL_D;
        end else if (d_r_req) begin
            grant = SEL_D;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arid_d       = arid_q;
        case (state_q)
            IDLE: begin
                if (i_r_req || d_r_req) begin
                    state_d      = AR;
                    owner_d      = grant;
                    last_grant_d = grant;
                    araddr_d     = (grant == SEL_D) ? d_r_addr : i_r_addr;
                    arlen_d      = (grant == SEL_D) ? d_r_length : i_r_length;
                    arsize_d     = (grant == SEL_D) ? d_r_size : i_r_size;
                    arid_d       = (grant == SEL_D) ? DCACHE_ID : ICACHE_ID;
                end
            end
            AR: begin
                if (arready) begin
                    state_d = R;
                end
            end
            R: begin
                if (rvalid && rready && rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= SEL_I;
            last_grant_q <= SEL_I;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arid_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arid_q       <= arid_d;
        end
    end

    assign arvalid = (state_q == AR);
    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arburst = 2'b01;

    assign ar_hs   = arvalid && arready;
    assign in_r    = (state_q == R);
    assign own_i   = (owner_q == SEL_I);
    assign own_d   = (owner_q == SEL_D);

    assign i_r_rdy = ar_hs && own_i;
    assign d_r_rdy = ar_hs && own_d;

    // Routing follows the owner only; rid is never used to steer beats.
    assign rready      = in_r && (own_d ? d_r_data_ready : i_r_data_ready);
    assign i_ret_valid = in_r && own_i && rvalid;
    assign i_ret_last  = in_r && own_i && rlast;
    assign d_ret_valid = in_r && own_d && rvalid;
    assign d_ret_last  = in_r && own_d && rlast;
    assign i_r_data    = rdata;
    assign d_r_data    = rdata;

`ifndef SYNTHESIS
    rid_match : assert property (
        @(posedge clk) disable iff (rst)
        (state_q == R && rvalid) |-> (rid == arid_q)
    ) else $error("rid %0h does not match arid %0h", rid, arid_q);
`endif

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read-address/read-data channel pair between the icache and the dcache refill/uncached-read ports.
- Each cache sees the same request interface it already drives: r_req/r_rdy plus the ret_valid/ret_last/r_data return beats.
- Exactly one read burst is outstanding at a time. Return beats are steered to the granted requester.
- Sits between the two caches and the top-level AXI master port. Write channels bypass this block.

Parameters:
- ICACHE_ID, 4'd0, arid driven for icache bursts.
- DCACHE_ID, 4'd1, arid driven for dcache bursts.
- FAIR, 1, 1 = alternate grant on a simultaneous request; 0 = dcache always wins.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_r_req  in  1  icache read request, held until i_r_rdy
- i_r_addr  in  32  icache burst start address
- i_r_size  in  3  icache beat size (AXI encoding)
- i_r_length  in  8  icache beats-1
- i_r_data_ready  in  1  icache accepts return beat
- i_r_rdy  out  1  icache address accepted (1-cycle pulse)
- i_ret_valid  out  1  icache return beat valid
- i_ret_last  out  1  icache last beat
- i_r_data  out  32  icache return data
- d_r_req, d_r_addr, d_r_size, d_r_length, d_r_data_ready  in  1/32/3/8/1  dcache equivalents of the i_ inputs
- d_r_rdy, d_ret_valid, d_ret_last, d_r_data  out  1/1/1/32  dcache equivalents of the i_ outputs
- arid  out  4  AXI read id
- araddr  out  32  AXI read address
- arlen  out  8  AXI burst length
- arsize  out  3  AXI beat size
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  AXI address valid
- arready  in  1  AXI address ready
- rid  in  4  AXI return id (checked only; see Behaviour)
- rdata  in  32  AXI return data
- rlast  in  1  AXI last beat
- rvalid  in  1  AXI beat valid
- rready  out  1  AXI beat ready

Behaviour:
- Reset values:
  - FSM = IDLE.
  - arvalid = 0; rready = 0.
  - All r_rdy and ret_valid outputs = 0.
  - Latched AR fields = 0.
  - owner = icache.
  - last_grant = icache, so the dcache wins the first tie.
- FSM states:
  - IDLE -> AR on any r_req.
  - AR -> R on arvalid & arready.
  - R -> IDLE on rvalid & rready & rlast.
  - No other transitions.
- Grant in IDLE:
  - Single requester: it is granted.
  - Both requesting with FAIR=1: grant the port that is not last_grant.
  - Both requesting with FAIR=0: grant the dcache.
  - On grant, the following are registered at the IDLE->AR edge: owner, last_grant, araddr, arlen, arsize, and arid (ICACHE_ID or DCACHE_ID).
- AR state:
  - arvalid = 1, driven from registers only. arvalid and the AR fields stay stable until arready.
  - owner's r_rdy = arvalid & arready (combinational, one cycle). The requester drops r_req after seeing it.
  - A non-owner r_req is held off. Its r_rdy stays 0 until it is granted in a later IDLE cycle.
- R state:
  - rready = owner's r_data_ready.
  - owner's ret_valid = rvalid; owner's ret_last = rlast; owner's r_data = rdata.
  - Non-owner ret_valid = 0. Both r_data outputs may carry rdata.
  - Beats transfer only on rvalid & rready. Back-to-back beats are allowed with no bubbles.
- Latency:
  - Request to arvalid: 1 cycle. A request in IDLE at cycle n gives arvalid at n+1.
  - rlast accepted to next arvalid: 2 cycles minimum (R->IDLE, then IDLE->AR).
- rid:
  - Routing is by owner, never by rid, because only one burst is in flight.
  - Under a simulation define, rid != latched arid fires an assertion.
- Width rules: arlen = r_length unchanged (beats-1); 8'd0 = single beat. A single-beat burst has rlast on its first beat, and the FSM returns to IDLE after that beat.
- Mid-burst rst: asynchronously returns to IDLE and deasserts arvalid, rready, and all ret_valid. Draining any in-flight AXI burst is the system's responsibility.
- Requester drops r_req before r_rdy: illegal. The latched request is still issued.

Test Plan:
- Icache-only request, addr=0x1C000040, len=15, arready on first cycle -> arvalid 1 cycle after r_req, arid=0, i_r_rdy pulses once, 16 beats routed to i_ret_*, i_ret_last on beat 16, d_ret_valid never 1.
- Both request in the same cycle after reset, FAIR=1 -> dcache granted first (arid=1). After its rlast, the icache is issued with arvalid exactly 2 cycles later. A repeat tie then grants the icache.
- FAIR=0, both continuously requesting for 3 bursts -> all three grants go to dcache; icache waits.
- Dcache uncached single beat, len=0, size=2, rvalid with d_r_data_ready=0 for 3 cycles -> rready low, beat held, accepted on the cycle d_r_data_ready=1, FSM returns to IDLE.
- arready stalled 5 cycles -> araddr/arlen/arid stable throughout; r_rdy pulses only on the handshake cycle.
- rst asserted on beat 4 of a 16-beat burst -> arvalid, rready, and ret_valid drop in the same cycle; after release, a new icache request is issued normally.
